memory_port_arbiter: RTL and testbench

Sequential 2:1 arbiter that shares one generic-bus memory port between the core's instruction bus and data bus. It sits between `RISCVBusiness_no_memory` (its I-bus and D-bus) and a single-ported memory or bus bridge. One transaction is granted at a time and held until the memory side completes it. Selection is either fixed data-priority or round-robin.

---
 rtl/memory_port_arbiter_pkg.sv | 22 ++
 rtl/memory_port_arbiter_pick2.sv | 29 ++
 rtl/memory_port_arbiter.sv | 133 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the I-bus/D-bus memory port arbiter.
//   arb_state_t : arbiter FSM state (2-bit)
//   requester_t : identifies a requester; also used to remember the last completed grant
//   other_req() : returns the requester that is not the argument (round-robin helper)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    function automatic requester_t other_req(input requester_t r);
        return (r == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_pick2.sv
// Combinational 2-way pick between the I-bus and D-bus requests.
//   i_pend, d_pend : requester pending flags (ren | wen)
//   last_grant     : requester that completed the most recent grant
//   pick           : chosen requester (meaningful only when valid)
//   valid          : at least one requester is pending
// DATA_PRIORITY = 1 gives the D-bus every tie; 0 alternates ties away from last_grant.
module arb_pick2
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic       i_pend,
    input  logic       d_pend,
    input  requester_t last_grant,
    output requester_t pick,
    output logic       valid
);

    always_comb begin
        valid = i_pend | d_pend;
        pick  = REQ_I;
        if (i_pend && d_pend) begin
            pick = (DATA_PRIORITY != 0) ? REQ_D : other_req(last_grant);
        end else if (d_pend) begin
            pick = REQ_D;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// 2:1 arbiter sharing one generic-bus memory port between the core I-bus and D-bus.
// One grant at a time, held until the memory side completes it (or the owner abandons),
// followed by one IDLE cycle that serves as the arbitration slot.
//   CLK, nRST                   : clock; synchronous active-high reset
//   i_ren/i_wen/i_addr/i_wdata/i_byte_en, i_busy/i_rdata : I-bus requester port
//   d_ren/d_wen/d_addr/d_wdata/d_byte_en, d_busy/d_rdata : D-bus requester port
//   m_ren/m_wen/m_addr/m_wdata/m_byte_en, m_busy/m_rdata : memory-side port
//   grant_d                     : debug, D-bus currently owns the port
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    // I-bus
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byte_en,
    output logic        i_busy,
    output logic [31:0] i_rdata,
    // D-bus
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_en,
    output logic        d_busy,
    output logic [31:0] d_rdata,
    // memory side
    output logic        m_ren,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byte_en,
    input  logic        m_busy,
    input  logic [31:0] m_rdata,
    // debug
    output logic        grant_d
);

    arb_state_t state_q;
    requester_t last_grant_q;
    requester_t pick;
    logic       pick_valid;
    logic       i_pend;
    logic       d_pend;

    assign i_pend = i_ren | i_wen;
    assign d_pend = d_ren | d_wen;

    arb_pick2 #(
        .DATA_PRIORITY(DATA_PRIORITY)
    ) u_pick (
        .i_pend    (i_pend),
        .d_pend    (d_pend),
        .last_grant(last_grant_q),
        .pick      (pick),
        .valid     (pick_valid)
    );

    // A grant ends either on completion (owner pending, m_busy low) or when the owner
    // drops its request; only a real completion updates last_grant.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_I;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= (pick == REQ_D) ? GRANT_D : GRANT_I;
                    end
                end
                GRANT_I: begin
                    if (!i_pend) begin
                        state_q <= IDLE;
                    end else if (!m_busy) begin
                        state_q      <= IDLE;
                        last_grant_q <= REQ_I;
                    end
                end
                GRANT_D: begin
                    if (!d_pend) begin
                        state_q <= IDLE;
                    end else if (!m_busy) begin
                        state_q      <= IDLE;
                        last_grant_q <= REQ_D;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_ren     = 1'b0;
        m_wen     = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_byte_en = '0;
        i_busy    = 1'b1;
        i_rdata   = '0;
        d_busy    = 1'b1;
        d_rdata   = '0;
        case (state_q)
            GRANT_I: begin
                m_ren     = i_ren;
                m_wen     = i_wen;
                m_addr    = i_addr;
                m_wdata   = i_wdata;
                m_byte_en = i_byte_en;
                i_busy    = m_busy;
                i_rdata   = m_rdata;
            end
            GRANT_D: begin
                m_ren     = d_ren;
                m_wen     = d_wen;
                m_addr    = d_addr;
                m_wdata   = d_wdata;
                m_byte_en = d_byte_en;
                d_busy    = m_busy;
                d_rdata   = m_rdata;
            end
            default: ;
        endcase
    end

    assign grant_d = (state_q == GRANT_D);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter. Two instances (D-priority and round-robin)
// share the same stimulus; a requester-level model predicts every output each cycle,
// and hand-computed literal checks pin the model at key points.
module tb_memory_port_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        i_ren, i_wen, d_ren, d_wen;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_byte_en, d_byte_en;
    logic        m_busy;
    logic [31:0] m_rdata;

    logic        m_ren1, m_wen1, i_busy1, d_busy1, grant_d1;
    logic [31:0] m_addr1, m_wdata1, i_rdata1, d_rdata1;
    logic [3:0]  m_byte_en1;
    logic        m_ren0, m_wen0, i_busy0, d_busy0, grant_d0;
    logic [31:0] m_addr0, m_wdata0, i_rdata0, d_rdata0;
    logic [3:0]  m_byte_en0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    memory_port_arbiter #(.DATA_PRIORITY(1)) u_dp1 (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_byte_en(i_byte_en), .i_busy(i_busy1), .i_rdata(i_rdata1),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_busy(d_busy1), .d_rdata(d_rdata1),
        .m_ren(m_ren1), .m_wen(m_wen1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_byte_en(m_byte_en1), .m_busy(m_busy), .m_rdata(m_rdata),
        .grant_d(grant_d1)
    );

    memory_port_arbiter #(.DATA_PRIORITY(0)) u_dp0 (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_byte_en(i_byte_en), .i_busy(i_busy0), .i_rdata(i_rdata0),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_busy(d_busy0), .d_rdata(d_rdata0),
        .m_ren(m_ren0), .m_wen(m_wen0), .m_addr(m_addr0), .m_wdata(m_wdata0),
        .m_byte_en(m_byte_en0), .m_busy(m_busy), .m_rdata(m_rdata),
        .grant_d(grant_d0)
    );

    // ---------------- requester-level model ----------------
    // owner: 0 = nobody, 1 = I-bus, 2 = D-bus.  last: 1 = I, 2 = D.
    typedef struct packed {
        logic        m_ren;
        logic        m_wen;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_byte_en;
        logic        i_busy;
        logic [31:0] i_rdata;
        logic        d_busy;
        logic [31:0] d_rdata;
        logic        grant_d;
    } obs_t;

    obs_t act1, act0;
    assign act1 = {m_ren1, m_wen1, m_addr1, m_wdata1, m_byte_en1,
                   i_busy1, i_rdata1, d_busy1, d_rdata1, grant_d1};
    assign act0 = {m_ren0, m_wen0, m_addr0, m_wdata0, m_byte_en0,
                   i_busy0, i_rdata0, d_busy0, d_rdata0, grant_d0};

    int own1, own0, last1, last0;
    bit model_ok = 1'b0;

    function automatic bit pend_of(input int who);
        if (who == 1) return i_ren | i_wen;
        if (who == 2) return d_ren | d_wen;
        return 1'b0;
    endfunction

    function automatic int next_own(input int own, input int last, input bit prio);
        bit ip = pend_of(1);
        bit dp = pend_of(2);
        if (own == 0) begin
            if (ip && dp) return prio ? 2 : (3 - last);
            if (ip) return 1;
            if (dp) return 2;
            return 0;
        end
        // owner keeps the port only while still asking and memory is still busy
        return (pend_of(own) && m_busy) ? own : 0;
    endfunction

    function automatic int next_last(input int own, input int last);
        if (own != 0 && pend_of(own) && !m_busy) return own;
        return last;
    endfunction

    function automatic obs_t expect_obs(input int own);
        obs_t e = '0;
        e.i_busy = 1'b1;
        e.d_busy = 1'b1;
        if (own == 1) begin
            e.m_ren = i_ren; e.m_wen = i_wen; e.m_addr = i_addr;
            e.m_wdata = i_wdata; e.m_byte_en = i_byte_en;
            e.i_busy = m_busy; e.i_rdata = m_rdata;
        end else if (own == 2) begin
            e.m_ren = d_ren; e.m_wen = d_wen; e.m_addr = d_addr;
            e.m_wdata = d_wdata; e.m_byte_en = d_byte_en;
            e.d_busy = m_busy; e.d_rdata = m_rdata; e.grant_d = 1'b1;
        end
        return e;
    endfunction

    always @(posedge CLK) begin
        if (nRST) begin
            own1 <= 0; own0 <= 0; last1 <= 1; last0 <= 1;
            model_ok <= 1'b1;
        end else begin
            own1  <= next_own(own1, last1, 1'b1);
            last1 <= next_last(own1, last1);
            own0  <= next_own(own0, last0, 1'b0);
            last0 <= next_last(own0, last0);
        end
    end

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL model_%s t=%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (model_ok) begin
            check_obs("dp1", act1, expect_obs(own1));
            check_obs("dp0", act0, expect_obs(own0));
        end
    end

    // ---------------- literal checks ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic lit1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    bit [7:0] exp_gd0, exp_ib0, exp_gd1;
    int       comp0;

    initial begin
        nRST = 1'b1;
        i_ren = 1'b1; i_wen = 1'b0; i_addr = 32'h0000_0040; i_wdata = '0; i_byte_en = 4'hF;
        d_ren = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0080; d_wdata = '0; d_byte_en = 4'hF;
        m_busy = 1'b0; m_rdata = 32'h0BAD_F00D;

        // reset held two cycles with both requesting
        next_cycle();
        mid();
        lit("rst_mreq1", {28'd0, m_ren1, m_wen1, m_byte_en1[1:0]}, 32'd0);
        lit("rst_maddr1", m_addr1, 32'd0);
        lit("rst_busy1", {30'd0, i_busy1, d_busy1}, 32'd3);
        lit1("rst_grant_d1", grant_d1, 1'b0);
        next_cycle();
        mid();
        lit("rst_maddr0", m_addr0, 32'd0);
        lit("rst_rdata0", i_rdata0 | d_rdata0, 32'd0);
        lit("rst_busy0", {30'd0, i_busy0, d_busy0}, 32'd3);
        next_cycle();
        nRST = 1'b0;
        mid();
        lit1("arb_idle_gd1", grant_d1, 1'b0);
        next_cycle();
        mid();
        lit1("first_grant_d1", grant_d1, 1'b1);
        lit1("first_grant_d0", grant_d0, 1'b1);
        lit1("first_dbusy1", d_busy1, 1'b0);
        lit1("first_ibusy1", i_busy1, 1'b1);
        next_cycle();
        i_ren = 1'b0; d_ren = 1'b0;
        repeat (2) begin mid(); next_cycle(); end

        // continuous contention, zero-wait memory
        i_ren = 1'b1; d_ren = 1'b1; i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        m_rdata = 32'hA5A5_0000; m_busy = 1'b0;
        exp_gd0 = 8'b1000_1000;
        exp_ib0 = 8'b1101_1101;
        exp_gd1 = 8'b1010_1010;
        comp0 = 0;
        for (int k = 0; k < 8; k++) begin
            mid();
            lit1($sformatf("rr_gd0_%0d", k), grant_d0, exp_gd0[k]);
            lit1($sformatf("rr_ib0_%0d", k), i_busy0, exp_ib0[k]);
            lit1($sformatf("dp_gd1_%0d", k), grant_d1, exp_gd1[k]);
            lit1($sformatf("dp_ib1_%0d", k), i_busy1, 1'b1);
            if (!i_busy0 || !d_busy0) comp0++;
            next_cycle();
        end
        lit("rr_completions", comp0, 32'd4);
        i_ren = 1'b0; d_ren = 1'b0;
        mid(); next_cycle();

        // lone I read, zero-wait
        i_ren = 1'b1; i_addr = 32'h8000_0000; m_rdata = 32'hDEAD_BEEF; m_busy = 1'b0;
        mid();
        lit1("rd_idle_mren0", m_ren0, 1'b0);
        lit1("rd_idle_ibusy0", i_busy0, 1'b1);
        next_cycle();
        mid();
        lit1("rd_mren0", m_ren0, 1'b1);
        lit("rd_maddr0", m_addr0, 32'h8000_0000);
        lit("rd_maddr1", m_addr1, 32'h8000_0000);
        lit1("rd_ibusy0", i_busy0, 1'b0);
        lit("rd_irdata0", i_rdata0, 32'hDEAD_BEEF);
        lit1("rd_dbusy0", d_busy0, 1'b1);
        lit("rd_drdata0", d_rdata0, 32'd0);
        next_cycle();
        i_ren = 1'b0;
        mid(); next_cycle();

        // D write with three busy cycles, I request raised mid-transfer
        d_wen = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678; d_byte_en = 4'hF;
        m_busy = 1'b1;
        mid();
        lit1("wr_idle_dbusy0", d_busy0, 1'b1);
        next_cycle();
        mid();
        lit1("wr_mwen0", m_wen0, 1'b1);
        lit("wr_maddr0", m_addr0, 32'h0000_0100);
        lit("wr_mwdata0", m_wdata0, 32'h1234_5678);
        lit("wr_mbe0", {28'd0, m_byte_en0}, 32'hF);
        lit1("wr_dbusy0_a", d_busy0, 1'b1);
        next_cycle();
        i_ren = 1'b1; i_addr = 32'h0000_0200;
        mid();
        lit1("wr_mwen0_b", m_wen0, 1'b1);
        lit1("wr_dbusy0_b", d_busy0, 1'b1);
        lit1("wr_ibusy0_b", i_busy0, 1'b1);
        next_cycle();
        mid();
        lit1("wr_dbusy0_c", d_busy0, 1'b1);
        next_cycle();
        m_busy = 1'b0;
        mid();
        lit1("wr_done_dbusy0", d_busy0, 1'b0);
        lit1("wr_done_mwen0", m_wen0, 1'b1);
        next_cycle();
        d_wen = 1'b0;
        mid();
        lit1("wr_gap_gd0", grant_d0, 1'b0);
        lit1("wr_gap_mren0", m_ren0, 1'b0);
        lit1("wr_gap_ibusy0", i_busy0, 1'b1);
        next_cycle();
        mid();
        lit1("wr_igrant_mren0", m_ren0, 1'b1);
        lit("wr_igrant_maddr0", m_addr0, 32'h0000_0200);
        lit("wr_igrant_maddr1", m_addr1, 32'h0000_0200);
        lit1("wr_igrant_ibusy0", i_busy0, 1'b0);
        next_cycle();
        i_ren = 1'b0;
        mid(); next_cycle();

        // D abandons its read while memory is busy; last grant (I) must be kept
        d_ren = 1'b1; d_addr = 32'h0000_0300; m_busy = 1'b1;
        mid(); next_cycle();
        mid();
        lit1("ab_gd0", grant_d0, 1'b1);
        lit1("ab_mren0", m_ren0, 1'b1);
        next_cycle();
        d_ren = 1'b0;
        mid();
        lit1("ab_drop_gd0", grant_d0, 1'b1);
        lit1("ab_drop_mren0", m_ren0, 1'b0);
        lit1("ab_drop_dbusy0", d_busy0, 1'b1);
        next_cycle();
        i_ren = 1'b1; d_ren = 1'b1; m_busy = 1'b0;
        mid();
        lit1("ab_idle_gd0", grant_d0, 1'b0);
        next_cycle();
        mid();
        lit1("ab_last_kept_gd0", grant_d0, 1'b1);
        next_cycle();
        i_ren = 1'b0; d_ren = 1'b0;
        mid(); next_cycle();

        // reset during a busy D write
        d_wen = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'hCAFE_0001; m_busy = 1'b1;
        mid(); next_cycle();
        mid();
        lit1("rstx_mwen0", m_wen0, 1'b1);
        lit1("rstx_gd1", grant_d1, 1'b1);
        next_cycle();
        nRST = 1'b1;
        mid();
        lit1("rstx_hold_mwen0", m_wen0, 1'b1);
        next_cycle();
        mid();
        lit1("rstx_mwen0_off", m_wen0, 1'b0);
        lit1("rstx_mwen1_off", m_wen1, 1'b0);
        lit1("rstx_gd0_off", grant_d0, 1'b0);
        lit1("rstx_dbusy0", d_busy0, 1'b1);
        lit1("rstx_ibusy0", i_busy0, 1'b1);
        next_cycle();
        nRST = 1'b0; d_wen = 1'b0;
        repeat (2) begin mid(); next_cycle(); end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
